pipe_subtractor16: RTL and testbench
====================================

// Module: pipe_subtractor16
// PURPOSE
//  Pipelined WIDTH-bit subtractor: diff = a - b - bin, with borrow-out. The inverse-direction
//  companion of the generate-built ripple adder. The borrow chain is cut into SLICE-bit
//  stages, with one register stage per slice, to meet timing.
//  Streaming valid/ready on both sides; sits between operand producers and the datapath
//  consumer.
// PARAMETERS
//  WIDTH   16  operand width; must be a multiple of SLICE
//  SLICE    4  bits resolved per pipeline stage
//  STAGES  WIDTH/SLICE (derived localparam, 4)  pipeline depth = latency in cycles
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_a       in   WIDTH  minuend
//  in_b       in   WIDTH  subtrahend
//  in_bin     in   1      borrow-in
//  in_valid   in   1      operands valid
//  in_ready   out  1      block accepts operands this cycle
//  out_diff   out  WIDTH  (a - b - bin) mod 2^WIDTH
//  out_bout   out  1      borrow-out: 1 iff a < b + bin (unsigned)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result this cycle
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): every stage valid bit = 0; every stage data/borrow register = 0.
//    So out_valid=0, out_diff=0, out_bout=0. in_ready=1 from the first cycle after reset.
//  - Transfer on a side happens when valid && ready at the posedge. in_ready has no
//    combinational dependence on in_valid. out_valid/out_diff/out_bout come straight from the
//    last stage's registers.
//  - Stage k (0..STAGES-1) holds:
//    * valid_k
//    * the resolved low diff bits [(k+1)*SLICE-1:0]
//    * the borrow out of slice k
//    * the unresolved high operand bits of a and b
//  - Stage 0 registers slice 0 = a[S-1:0] - b[S-1:0] - bin. Stage k registers slice k using the
//    borrow held in stage k-1.
//  - Flow: adv_k = !valid_k || adv_{k+1}, with adv_STAGES = out_ready. in_ready = adv_0.
//    Bubbles collapse, so a stalled output does not block stages that are empty.
//  - When adv_k is true, stage k loads stage k-1's contents (or the input port for k=0) together
//    with that valid bit. Otherwise stage k holds.
//  - Latency: exactly STAGES cycles from input acceptance to out_valid when out_ready=1 held high.
//    Throughput is 1 result per cycle. Results leave in order; none is dropped or duplicated.
//  - While out_valid=1 and out_ready=0, out_diff and out_bout stay stable. After all stages fill,
//    in_ready=0.
//  - Arithmetic per slice: {bo, d} = {1'b0, a_s} - {1'b0, b_s} - bi, computed (SLICE+1) bits wide.
//    bo = MSB of that result. Wrap-around is mod 2^WIDTH. out_bout is the final slice's bo.
//  - Simultaneous accept and emit in the same cycle is legal when the pipe is full and
//    out_ready=1.
//  - Reset mid-operation discards all in-flight operations; no result is emitted for them.
//  - in_* values while in_valid=0 are don't-care and never reach the output.
// STRUCTURE
//  - Shared package: SUB_WIDTH=16, SUB_SLICE=4 defaults, and a stage-record typedef
//    {valid, diff, bout, a_hi, b_hi}.
//  - Sub-module sub_slice (SLICE-bit combinational subtract with borrow in/out). It is
//    instantiated STAGES times inside a generate-for loop. Stage registers and flow control
//    are in the top module.
// TESTING
//  1. Reset, then a=16'h1234, b=16'h0034, bin=0 -> after 4 cycles out_diff=16'h1200, out_bout=0.
//  2. a=16'h0000, b=16'h0001, bin=0 -> out_diff=16'hFFFF, out_bout=1. Then a=16'h0005, b=16'h0005,
//     bin=1 -> out_diff=16'hFFFF, out_bout=1.
//  3. Cross-slice borrow: a=16'h1000, b=16'h0001, bin=0 -> out_diff=16'h0FFF, out_bout=0.
//  4. Stream 8 back-to-back ops with out_ready=1 -> 8 consecutive out_valid cycles, in order,
//    first result 4 cycles after the first input.
//  5. Backpressure: hold out_ready=0 and offer 6 ops -> in_ready drops after 4 accepts and the
//    output stays stable. Release -> all 4 drain in order, then the next ops are accepted.
//  6. Pull rst_n low while 3 ops are in flight -> next cycle out_valid=0, out_diff=0, in_ready=1,
//    and no stale result appears afterwards.
//  - Also run 10k random ops with random valid/ready against a reference model of
//    (a - b - bin) mod 2^16 and borrow (a < b + bin).

Source files
------------

// File: rtl/pipe_subtractor16_pkg.sv
// Shared definitions for the pipelined subtractor.
//   SUB_WIDTH / SUB_SLICE : default operand width and bits resolved per stage
//   SUB_STAGES            : derived pipeline depth
//   stage_t               : contents of one pipeline stage register
package pipe_subtractor16_pkg;

    localparam int SUB_WIDTH  = 16;
    localparam int SUB_SLICE  = 4;
    localparam int SUB_STAGES = SUB_WIDTH / SUB_SLICE;

    // diff holds the low difference bits resolved so far (upper bits zero).
    // a_hi/b_hi hold the not-yet-consumed operand bits, right-aligned, so
    // every stage reads its slice from bits [SUB_SLICE-1:0].
    typedef struct packed {
        logic                           valid;
        logic [SUB_WIDTH-1:0]           diff;
        logic                           bout;
        logic [SUB_WIDTH-SUB_SLICE-1:0] a_hi;
        logic [SUB_WIDTH-SUB_SLICE-1:0] b_hi;
    } stage_t;

endpackage

// File: rtl/pipe_subtractor16_sub_slice.sv
// sub_slice: SLICE-bit combinational subtract with borrow in/out.
//   a, b  : slice operands
//   bin   : borrow into this slice
//   diff  : (a - b - bin) mod 2^SLICE
//   bout  : borrow out of this slice (1 iff a < b + bin)
module sub_slice
    import pipe_subtractor16_pkg::*;
#(
    parameter int SLICE = SUB_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
    output logic [SLICE-1:0] diff,
    output logic             bout
);

    // One extra bit wide: the MSB of the zero-extended difference is the borrow.
    logic [SLICE:0] res;

    assign res          = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
    assign {bout, diff} = res;

endmodule

// File: rtl/pipe_subtractor16.sv
// pipe_subtractor16: pipelined diff = a - b - bin with borrow-out.
// The borrow chain is cut into SLICE-bit pieces, one register stage per piece,
// with valid/ready handshakes on both sides and bubble-collapsing flow control.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_a, in_b, in_bin  : minuend, subtrahend, borrow-in
//   in_valid / in_ready : input handshake
//   out_diff, out_bout  : (a - b - bin) mod 2^WIDTH, borrow-out
//   out_valid/out_ready : output handshake
module pipe_subtractor16
    import pipe_subtractor16_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int SLICE = SUB_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int STAGES = WIDTH / SLICE;

    // The stage record is sized by the package constants.
    if (WIDTH != SUB_WIDTH || SLICE != SUB_SLICE || WIDTH % SLICE != 0) begin : g_bad_param
        $error("pipe_subtractor16: WIDTH/SLICE must match pipe_subtractor16_pkg");
    end

    stage_t                        st  [STAGES];
    stage_t                        nxt [STAGES];
    logic [STAGES-1:0]             adv;
    logic [STAGES-1:0][SLICE-1:0]  sa, sb, sd;
    logic [STAGES-1:0]             sbi, sbo;

    // A stage may load when it is empty or when everything downstream of it
    // will move; written in closed form so no signal depends on its own bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            adv[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!st[j].valid) adv[k] = 1'b1;
            end
        end
    end

    // Slice operands: stage 0 from the ports, later stages from the
    // operand bits and borrow carried by the previous stage.
    always_comb begin
        sa  = '0;
        sb  = '0;
        sbi = '0;
        sa[0]  = in_a[SLICE-1:0];
        sb[0]  = in_b[SLICE-1:0];
        sbi[0] = in_bin;
        for (int k = 1; k < STAGES; k++) begin
            sa[k]  = st[k-1].a_hi[SLICE-1:0];
            sb[k]  = st[k-1].b_hi[SLICE-1:0];
            sbi[k] = st[k-1].bout;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        sub_slice #(.SLICE(SLICE)) u_slice (
            .a    (sa[k]),
            .b    (sb[k]),
            .bin  (sbi[k]),
            .diff (sd[k]),
            .bout (sbo[k])
        );
    end

    // Next contents of each stage: previous stage's record with one more
    // slice resolved and the consumed operand bits shifted out.
    always_comb begin
        for (int k = 0; k < STAGES; k++) nxt[k] = '0;

        nxt[0].valid            = in_valid;
        nxt[0].diff[SLICE-1:0]  = sd[0];
        nxt[0].bout             = sbo[0];
        nxt[0].a_hi             = in_a[WIDTH-1:SLICE];
        nxt[0].b_hi             = in_b[WIDTH-1:SLICE];

        for (int k = 1; k < STAGES; k++) begin
            nxt[k].valid                 = st[k-1].valid;
            nxt[k].diff                  = st[k-1].diff;
            nxt[k].diff[k*SLICE +: SLICE] = sd[k];
            nxt[k].bout                  = sbo[k];
            nxt[k].a_hi                  = st[k-1].a_hi >> SLICE;
            nxt[k].b_hi                  = st[k-1].b_hi >> SLICE;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (!rst_n) begin
                // NOTE: data registers are cleared too, not just valid, so out_diff/out_bout read 0 after reset.
                st[k] <= '0;
            end else if (adv[k]) begin
                // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
                st[k] <= nxt[k];
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = st[STAGES-1].valid;
    assign out_diff  = st[STAGES-1].diff;
    assign out_bout  = st[STAGES-1].bout;

endmodule

// File: tb/tb_pipe_subtractor16.sv
// Scoreboard bench for pipe_subtractor16: the driver pushes the expected
// result when an operand is accepted; a negedge monitor pops and compares
// whenever a result transfers, and checks stability while stalled.
module tb_pipe_subtractor16;

    localparam int W      = 16;
    localparam int STAGES = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_bin = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_diff;
    logic         out_bout;
    logic         out_valid;
    logic         out_ready = 1'b1;

    always #5 clk = ~clk;

    pipe_subtractor16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bin    (in_bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_diff  (out_diff),
        .out_bout  (out_bout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   accepted = 0;
    int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, between driver updates.
    bit           stall_prev = 0;
    logic [W-1:0] prev_d;
    logic         prev_bo;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev && out_valid) begin
                check("stall_hold_diff", 32'(out_diff), 32'(prev_d));
                check("stall_hold_bout", 32'(out_bout), 32'(prev_bo));
            end
            stall_prev = out_valid && !out_ready;
            prev_d     = out_diff;
            prev_bo    = out_bout;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got diff %0h with nothing outstanding (t=%0t)",
                             out_diff, $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("result_diff", 32'(out_diff), 32'(e.d));
                    check("result_bout", 32'(out_bout), 32'(e.bo));
                    if (e.lat) check("latency", 32'(cyc - e.acc), 32'(STAGES));
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the operand is taken.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic ebo, input bit lat);
        int n    = 0;
        bit done = 0;
        in_a     = a;
        in_b     = b;
        in_bin   = bin;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{ed, ebo, cyc, lat});
                accepted++;
                done = 1;
            end else if (++n >= 500) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected 1", n);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_bin   = 1'($urandom);
    endtask

    // Reference model: plain unsigned arithmetic on the whole operands.
    task automatic send_model(input bit lat);
        logic [W-1:0] a, b, ed;
        logic         bin, ebo;
        a   = 16'($urandom);
        b   = 16'($urandom);
        bin = 1'($urandom);
        if ($urandom_range(0, 7) == 0) b = a;
        ed  = 16'((int'(a) - int'(b) - int'(bin)) & 32'hFFFF);
        ebo = (int'(a) < int'(b) + int'(bin));
        send(a, b, bin, ed, ebo, lat);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            in_a   = 16'($urandom);
            in_b   = 16'($urandom);
            in_bin = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_diff",  32'(out_diff),  32'd0);
        check("reset_out_bout",  32'(out_bout),  32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;

        // Directed values with known answers.
        send(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1);
        drain();
        send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1);
        send(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1);
        send(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1);
        drain();

        // Back-to-back stream with the consumer always ready.
        for (int i = 0; i < 8; i++) send_model(1);
        drain();

        // Backpressure: fill the pipe, then release.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        accepted = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_model(0);
            end
            begin
                repeat (12) @(negedge clk);
                check("bp_accepts",   32'(accepted),  32'd4);
                check("bp_in_ready",  32'(in_ready),  32'd0);
                check("bp_out_valid", 32'(out_valid), 32'd1);
                rdy_mode = 1;
            end
        join
        drain();
        check("bp_total_accepts", 32'(accepted), 32'd6);

        // Reset with operations in flight.
        for (int i = 0; i < 3; i++) send_model(0);
        rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_diff",  32'(out_diff),  32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);

        // Random traffic with random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            idle($urandom_range(0, 2));
            send_model(0);
        end
        rdy_mode = 1;
        drain();
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
